// File: rtl/cr_clint_arb.sv
// cr_clint_arb: round-robin two-port request arbiter/sequencer in front of the CLINT slave port.
// Optional completion timeout: define CLINT_ARB_TIMEOUT_EN.
module cr_clint_arb #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        m0_arb_sel,
  input  logic        m0_arb_write,
  input  logic [15:0] m0_arb_addr,
  input  logic [31:0] m0_arb_wdata,
  output logic        arb_m0_cmplt,
  output logic [31:0] arb_m0_rdata,
  output logic        arb_m0_err,
  input  logic        m1_arb_sel,
  input  logic        m1_arb_write,
  input  logic [15:0] m1_arb_addr,
  input  logic [31:0] m1_arb_wdata,
  output logic        arb_m1_cmplt,
  output logic [31:0] arb_m1_rdata,
  output logic        arb_m1_err,
  output logic        arb_clint_sel,
  output logic        arb_clint_write,
  output logic [15:0] arb_clint_addr,
  output logic [31:0] arb_clint_wdata,
  input  logic        clint_arb_cmplt,
  input  logic [31:0] clint_arb_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic p0, p1, w0, w1, owner, last_gnt, gnt, grant, busy, done, tmo, rsp, acc0, acc1, clr0, clr1;
  logic [15:0] a0, a1;
  logic [31:0] d0, d1;
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_range
    $error("TIMEOUT_CYC must be 1..255");
  end
  assign grant = state == IDLE && (p0 || p1);
  assign gnt   = (p0 && p1) ? ~last_gnt : p1;
  assign busy  = state == ISSUE || state == WAIT;
  assign done  = busy && clint_arb_cmplt;
  assign rsp   = done || tmo;
  assign clr0  = state == RESP && !owner;
  assign clr1  = state == RESP && owner;
  // a pulse in the owner's RESP cycle reloads the buffer (set wins over clear)
  assign acc0  = m0_arb_sel && (!p0 || clr0);
  assign acc1  = m1_arb_sel && (!p1 || clr1);
`ifdef CLINT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign tmo = busy && !clint_arb_cmplt && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || grant) cnt <= '0;
    else if (busy) cnt <= cnt + CW'(1);
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      arb_m0_err <= 1'b0;
      arb_m1_err <= 1'b0;
    end else begin
      arb_m0_err <= tmo && !owner;
      arb_m1_err <= tmo && owner;
    end
  end
`else
  assign tmo        = 1'b0;
  assign arb_m0_err = 1'b0;
  assign arb_m1_err = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = grant ? ISSUE : IDLE;
      ISSUE, WAIT: state_nx = rsp ? RESP : WAIT;
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state           <= IDLE;
      p0              <= 1'b0;
      p1              <= 1'b0;
      w0              <= 1'b0;
      w1              <= 1'b0;
      a0              <= '0;
      a1              <= '0;
      d0              <= '0;
      d1              <= '0;
      owner           <= 1'b0;
      last_gnt        <= 1'b1;
      arb_clint_sel   <= 1'b0;
      arb_clint_write <= 1'b0;
      arb_clint_addr  <= '0;
      arb_clint_wdata <= '0;
      arb_m0_cmplt    <= 1'b0;
      arb_m1_cmplt    <= 1'b0;
      arb_m0_rdata    <= '0;
      arb_m1_rdata    <= '0;
    end else begin
      state <= state_nx;
      p0    <= acc0 || (p0 && !clr0);
      p1    <= acc1 || (p1 && !clr1);
      if (acc0) begin
        w0 <= m0_arb_write;
        a0 <= m0_arb_addr;
        d0 <= m0_arb_wdata;
      end
      if (acc1) begin
        w1 <= m1_arb_write;
        a1 <= m1_arb_addr;
        d1 <= m1_arb_wdata;
      end
      arb_clint_sel <= grant;
      // payload captured at grant stays stable through ISSUE and WAIT
      if (grant) begin
        owner           <= gnt;
        last_gnt        <= gnt;
        arb_clint_write <= gnt ? w1 : w0;
        arb_clint_addr  <= gnt ? a1 : a0;
        arb_clint_wdata <= gnt ? d1 : d0;
      end
      arb_m0_cmplt <= rsp && !owner;
      arb_m1_cmplt <= rsp && owner;
      arb_m0_rdata <= (done && !owner && !arb_clint_write) ? clint_arb_rdata : '0;
      arb_m1_rdata <= (done && owner && !arb_clint_write) ? clint_arb_rdata : '0;
    end
  end
endmodule

// File: doc/cr_clint_arb.md
# cr_clint_arb

Two-port request arbiter and sequencer in front of the CLINT register slave port. It buffers one request per port and arbitrates round-robin between the CPU tightly-coupled port (m0) and the system/debug port (m1). It issues exactly one CLINT bus transaction at a time and routes the completion and read data back to the owning requester. It sits between the TCIPIF/debug masters and the CLINT `tcipif_clint_*` slave interface.

## Interface
- `TIMEOUT_CYC`, 16, cycles allowed from issue to CLINT completion before an error response (range 1..255; used only with the timeout feature)
- `forever_cpuclk`  in  1  the single clock; all logic is on the rising edge
- `cpurst`  in  1  reset, synchronous, active-high
- `m0_arb_sel`  in  1  one-cycle request pulse from port 0; payload sampled with it
- `m0_arb_write`  in  1  port 0: 1 = write, 0 = read
- `m0_arb_addr`  in  16  port 0 register address
- `m0_arb_wdata`  in  32  port 0 write data
- `arb_m0_cmplt`  out  1  one-cycle completion pulse to port 0
- `arb_m0_rdata`  out  32  read data to port 0, valid with `arb_m0_cmplt`
- `arb_m0_err`  out  1  error flag to port 0, valid with `arb_m0_cmplt`
- `m1_arb_sel`, `m1_arb_write`, `m1_arb_addr`, `m1_arb_wdata`, `arb_m1_cmplt`, `arb_m1_rdata`, `arb_m1_err`: same directions, widths and meaning for port 1
- `arb_clint_sel`  out  1  CLINT select, high for exactly one cycle per transaction
- `arb_clint_write`  out  1  CLINT write strobe qualifier
- `arb_clint_addr`  out  16  CLINT address
- `arb_clint_wdata`  out  32  CLINT write data
- `clint_arb_cmplt`  in  1  CLINT completion
- `clint_arb_rdata`  in  32  CLINT read data, valid with `clint_arb_cmplt`

## Operation
- Per-port one-deep buffer: pending flag plus write/addr/wdata, loaded on the `mX_arb_sel` pulse.
- A pulse arriving while that port's pending flag is already set is dropped; this is a protocol violation.
- A pulse in the same cycle as that port's RESP is accepted, because set wins over clear. Requesters may therefore reissue in the cycle they see `cmplt`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: any pending → grant and latch the owner → ISSUE.
  - ISSUE: `arb_clint_sel` = 1 and payload driven from the owner's buffer. If `clint_arb_cmplt` is high → RESP, else → WAIT.
  - WAIT: `arb_clint_sel` = 0 with payload held stable. `clint_arb_cmplt` → RESP.
  - RESP: owner's `cmplt` = 1, `rdata` comes from a register captured on `clint_arb_cmplt`, `err` = 0. Clear the owner's pending flag → IDLE.
- Arbitration is round-robin on a `last_gnt` register. If both ports are pending, the port that is not `last_gnt` wins. `last_gnt` updates on grant.
- Write transactions return `rdata` = 0.
- `clint_arb_cmplt` is ignored outside ISSUE and WAIT.
- All outputs are registered. The `cmplt`/`err` of the non-owning port stay 0.

## Timing
- Reset (synchronous, `cpurst` = 1 at a rising edge):
  - FSM → IDLE, pending flags cleared, `last_gnt` = 1 (so m0 wins the first tie).
  - All outputs 0.
- Reset mid-transaction: the in-flight and buffered requests are discarded and no `cmplt` is generated. `arb_clint_sel` is 0 from the cycle after the reset edge.
- Best-case latency, with the CLINT completing in the issue cycle:
  - `sel` pulse in cycle 0.
  - Pending in cycle 1 (IDLE grants).
  - `arb_clint_sel` in cycle 2.
  - `arb_mX_cmplt` in cycle 3.
- Each extra CLINT wait cycle adds one cycle of latency.
- Throughput is one transaction per 3 cycles when both ports are kept loaded.

## Configuration
- `CLINT_ARB_TIMEOUT_EN` defined:
  - A counter of width ceil(log2(`TIMEOUT_CYC`+1)) clears on entering ISSUE and increments each ISSUE/WAIT cycle without completion.
  - When it reaches `TIMEOUT_CYC` → RESP with `err` = 1 and `rdata` = 0.
  - A later stray `clint_arb_cmplt` is ignored under the rule above.
- `CLINT_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT persists until completion.
  - `arb_m0_err` and `arb_m1_err` are tied to 0.

## Test plan
- Single m0 read: pulse `m0_arb_sel` at cycle 0 with addr 0x4000, CLINT returns cmplt in issue cycle with rdata 0x1234_5678 → `arb_clint_sel` only in cycle 2; `arb_m0_cmplt` = 1 with rdata 0x1234_5678 in cycle 3; m1 outputs stay 0.
- Simultaneous m0 and m1 requests after reset → m0 issued first, then m1. Repeat both again → order m0, m1 (alternating). `arb_clint_addr` and `arb_clint_wdata` are held stable through a 2-cycle CLINT wait.
- m0 write of 0xFFFF_FFFF to 0x4004 with a 3-cycle CLINT wait → `arb_clint_write` = 1 and wdata held for 3 cycles; `arb_m0_cmplt` 1 cycle after the CLINT cmplt, rdata 0.
- Back-to-back: m0 reissues in its RESP cycle, and a second pulse arrives while pending → first reissue is serviced; the duplicate is dropped; exactly two `cmplt` pulses in total.
- `cpurst` asserted in WAIT with m1 pending → no `cmplt` on either port; all outputs 0; the next m1 request completes normally.
- With `CLINT_ARB_TIMEOUT_EN`, `TIMEOUT_CYC` = 4, CLINT never completes → `arb_m0_cmplt` = 1 with `err` = 1 and rdata 0, 4 cycles after ISSUE entry. A stray cmplt in the following IDLE is ignored.
